xor_bank_buffer: RTL and testbench

- Parametrised successor to the raw/OTP RAM array and XOR read path in the top level.
- Holds BANKS pairs of memories: an OTP bank and a raw-data bank per pair.
- Tracks per-bank ownership flags, so the OTP generator and the SD engine hand banks over by handshake instead of by implicit timing.
- Adds a readiness count, bypass (raw-only) reads and sticky protocol-error detection. All of this runs on one clock.

---
 rtl/xor_bank_buffer_pkg.sv | 16 +
 rtl/xor_bank_buffer_if.sv | 58 +++++
 rtl/sdp_ram_param.sv | 41 ++++
 rtl/xor_bank_buffer.sv | 180 ++++++++++++++++++
 tb/tb_xor_bank_buffer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/xor_bank_buffer_pkg.sv
// Shared defaults and types for the XOR bank buffer.
package xor_bank_buffer_pkg;

  // Default geometry used by the top level and its interface.
  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefDepth = 1024;
  localparam int unsigned DefBanks = 8;

  // Read-side control registered alongside the synchronous RAM read.
  typedef struct packed {
    logic valid;
    logic eligible;
    logic bypass;
  } rd_ctl_t;

endpackage

// File: rtl/xor_bank_buffer_if.sv
// Bus interface of the XOR bank buffer: OTP write, raw write, read and control.
interface xor_bank_buffer_if
  import xor_bank_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned BANKS  = DefBanks
) ();

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned SEL_W  = $clog2(BANKS);

  // OTP generator side
  logic [SEL_W-1:0]  iotp_sel;
  logic [ADDR_W-1:0] iotp_addr;
  logic [DATA_W-1:0] iotp_wdata;
  logic              iotp_we;
  logic              iotp_commit;

  // Raw-data side
  logic [SEL_W-1:0]  iraw_sel;
  logic [ADDR_W-1:0] iraw_addr;
  logic [DATA_W-1:0] iraw_wdata;
  logic              iraw_we;
  logic              iraw_commit;

  // SD engine read side
  logic [SEL_W-1:0]  ird_sel;
  logic [ADDR_W-1:0] ird_addr;
  logic              ird_en;
  logic              ibypass;
  logic              irelease;
  logic              ierr_clr;

  // Results and status
  logic [DATA_W-1:0] ordata;
  logic              ordata_valid;
  logic [BANKS-1:0]  ootp_free;
  logic [BANKS-1:0]  oraw_free;
  logic [BANKS-1:0]  obank_ready;
  logic [SEL_W:0]    oready_cnt;
  logic              oerr;

  modport master (
    output iotp_sel, iotp_addr, iotp_wdata, iotp_we, iotp_commit,
    output iraw_sel, iraw_addr, iraw_wdata, iraw_we, iraw_commit,
    output ird_sel, ird_addr, ird_en, ibypass, irelease, ierr_clr,
    input  ordata, ordata_valid, ootp_free, oraw_free, obank_ready, oready_cnt, oerr
  );

  modport slave (
    input  iotp_sel, iotp_addr, iotp_wdata, iotp_we, iotp_commit,
    input  iraw_sel, iraw_addr, iraw_wdata, iraw_we, iraw_commit,
    input  ird_sel, ird_addr, ird_en, ibypass, irelease, ierr_clr,
    output ordata, ordata_valid, ootp_free, oraw_free, obank_ready, oready_cnt, oerr
  );

endinterface

// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module sdp_ram_param #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only moves on an enabled read, otherwise the last word is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xor_bank_buffer.sv
// Banked OTP/raw buffer with handshake ownership flags, XOR or bypass reads,
// readiness count and a sticky protocol-error flag.
module xor_bank_buffer
  import xor_bank_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned BANKS  = DefBanks
) (
  input logic               iclk,
  input logic               irst_n,
  xor_bank_buffer_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(BANKS);

  logic [BANKS-1:0] otp_v_q, otp_v_d;
  logic [BANKS-1:0] raw_v_q, raw_v_d;
  logic             err_q, err_d;
  rd_ctl_t          rd_q, rd_d;
  logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [BANKS-1:0] otp_we, raw_we, rd_re;
  logic [BANKS-1:0] ready;
  logic             eligible;
  logic             flag_err, wr_err, rd_err;
  logic [DATA_W-1:0] rd_word;
  logic [SEL_W:0]   ready_cnt;

  logic [DATA_W-1:0] otp_rdata [BANKS];
  logic [DATA_W-1:0] raw_rdata [BANKS];

  assign ready = otp_v_q & raw_v_q;

  // Per-bank write/read enables; writes are gated by the pre-edge ownership flag.
  always_comb begin
    otp_we = '0;
    raw_we = '0;
    rd_re  = '0;
    for (int i = 0; i < BANKS; i++) begin
      otp_we[i] = bus.iotp_we && (bus.iotp_sel == SEL_W'(i)) && !otp_v_q[i];
      raw_we[i] = bus.iraw_we && (bus.iraw_sel == SEL_W'(i)) && !raw_v_q[i];
      rd_re[i]  = bus.ird_en && (bus.ird_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    sdp_ram_param #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_otp_ram (
      .clk_i  (iclk),
      .we_i   (otp_we[g]),
      .waddr_i(bus.iotp_addr),
      .wdata_i(bus.iotp_wdata),
      .re_i   (rd_re[g]),
      .raddr_i(bus.ird_addr),
      .rdata_o(otp_rdata[g])
    );

    sdp_ram_param #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_raw_ram (
      .clk_i  (iclk),
      .we_i   (raw_we[g]),
      .waddr_i(bus.iraw_addr),
      .wdata_i(bus.iraw_wdata),
      .re_i   (rd_re[g]),
      .raddr_i(bus.ird_addr),
      .rdata_o(raw_rdata[g])
    );
  end

  // Ownership flags: commits set, a release on a ready bank clears both and wins.
  always_comb begin
    logic oc, rc, rel;
    otp_v_d  = otp_v_q;
    raw_v_d  = raw_v_q;
    flag_err = 1'b0;
    oc       = 1'b0;
    rc       = 1'b0;
    rel      = 1'b0;
    for (int i = 0; i < BANKS; i++) begin
      oc  = bus.iotp_commit && (bus.iotp_sel == SEL_W'(i));
      rc  = bus.iraw_commit && (bus.iraw_sel == SEL_W'(i));
      rel = bus.irelease && (bus.ird_sel == SEL_W'(i));
      if (rel && ready[i]) begin
        otp_v_d[i] = 1'b0;
        raw_v_d[i] = 1'b0;
        if (oc || rc) begin
          flag_err = 1'b1;
        end
      end else begin
        if (oc) begin
          otp_v_d[i] = 1'b1;
        end
        if (rc) begin
          raw_v_d[i] = 1'b1;
        end
        // Releasing a bank that is not ready, or re-committing a set flag.
        if (rel || (oc && otp_v_q[i]) || (rc && raw_v_q[i])) begin
          flag_err = 1'b1;
        end
      end
    end
  end

  // Read eligibility and error sources, all judged on pre-edge flags.
  always_comb begin
    eligible = bus.ibypass ? raw_v_q[bus.ird_sel] : ready[bus.ird_sel];
    wr_err   = (bus.iotp_we && otp_v_q[bus.iotp_sel]) ||
               (bus.iraw_we && raw_v_q[bus.iraw_sel]);
    rd_err   = bus.ird_en && !eligible;
    err_d    = err_q;
    if (flag_err || wr_err || rd_err) begin
      err_d = 1'b1;
    end else if (bus.ierr_clr) begin
      err_d = 1'b0;
    end
  end

  // Read control captured with the RAM read; held between requests.
  always_comb begin
    rd_d       = rd_q;
    rd_sel_d   = rd_sel_q;
    rd_d.valid = bus.ird_en;
    if (bus.ird_en) begin
      rd_d.eligible = eligible;
      rd_d.bypass   = bus.ibypass;
      rd_sel_d      = bus.ird_sel;
    end
  end

  // Output mux; ordata keeps its last value while no read result is presented.
  always_comb begin
    rd_word = '0;
    if (rd_q.eligible) begin
      rd_word = rd_q.bypass ? raw_rdata[rd_sel_q] : (raw_rdata[rd_sel_q] ^ otp_rdata[rd_sel_q]);
    end
    hold_d = rd_q.valid ? rd_word : hold_q;
  end

  // Flag, error, read-control and output-hold registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      otp_v_q  <= '0;
      raw_v_q  <= '0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      rd_sel_q <= '0;
      hold_q   <= '0;
    end else begin
      otp_v_q  <= otp_v_d;
      raw_v_q  <= raw_v_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      rd_sel_q <= rd_sel_d;
      hold_q   <= hold_d;
    end
  end

  // Population count of ready banks.
  always_comb begin
    ready_cnt = '0;
    for (int i = 0; i < BANKS; i++) begin
      ready_cnt = ready_cnt + (SEL_W + 1)'(ready[i]);
    end
  end

  assign bus.ordata       = hold_d;
  assign bus.ordata_valid = rd_q.valid;
  assign bus.ootp_free    = ~otp_v_q;
  assign bus.oraw_free    = ~raw_v_q;
  assign bus.obank_ready  = ready;
  assign bus.oready_cnt   = ready_cnt;
  assign bus.oerr         = err_q;

endmodule

// File: tb/tb_xor_bank_buffer.sv
// Directed self-checking bench for xor_bank_buffer.
module tb_xor_bank_buffer;

  logic iclk;
  logic irst_n;
  int   n_cmp;
  int   n_fail;

  xor_bank_buffer_if #(.DATA_W(4), .DEPTH(1024), .BANKS(8)) bus ();

  xor_bank_buffer #(
    .DATA_W(4),
    .DEPTH (1024),
    .BANKS (8)
  ) dut (
    .iclk  (iclk),
    .irst_n(irst_n),
    .bus   (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.iotp_we     = 1'b0;
    bus.iotp_commit = 1'b0;
    bus.iraw_we     = 1'b0;
    bus.iraw_commit = 1'b0;
    bus.ird_en      = 1'b0;
    bus.irelease    = 1'b0;
    bus.ierr_clr    = 1'b0;
  endtask

  task automatic clear_err();
    bus.ierr_clr = 1'b1;
    tick();
    bus.ierr_clr = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    irst_n = 1'b1;
    bus.iotp_sel = 3'd0; bus.iotp_addr = 10'd0; bus.iotp_wdata = 4'h0;
    bus.iraw_sel = 3'd0; bus.iraw_addr = 10'd0; bus.iraw_wdata = 4'h0;
    bus.ird_sel  = 3'd0; bus.ird_addr  = 10'd0; bus.ibypass    = 1'b0;
    idle();
    #2 irst_n = 1'b0;
    tick();
    check("rst_ordata", 32'(bus.ordata), 32'h0);
    check("rst_valid", 32'(bus.ordata_valid), 32'h0);
    check("rst_err", 32'(bus.oerr), 32'h0);
    check("rst_otp_free", 32'(bus.ootp_free), 32'hFF);
    check("rst_raw_free", 32'(bus.oraw_free), 32'hFF);
    check("rst_ready", 32'(bus.obank_ready), 32'h00);
    check("rst_cnt", 32'(bus.oready_cnt), 32'h0);
    tick();
    irst_n = 1'b1;
    tick();

    // 1: fill bank 2 (OTP = low address bits, raw = F), commit both, XOR read.
    bus.iotp_sel = 3'd2;
    for (int a = 0; a < 1024; a++) begin
      bus.iotp_we = 1'b1; bus.iotp_addr = 10'(a); bus.iotp_wdata = 4'(a);
      tick();
    end
    bus.iotp_we = 1'b0; bus.iotp_commit = 1'b1;
    tick();
    bus.iotp_commit = 1'b0;
    check("otp_free_b2", 32'(bus.ootp_free), 32'hFB);
    check("ready_otp_only", 32'(bus.obank_ready), 32'h00);
    bus.iraw_sel = 3'd2;
    for (int a = 0; a < 1024; a++) begin
      bus.iraw_we = 1'b1; bus.iraw_addr = 10'(a); bus.iraw_wdata = 4'hF;
      tick();
    end
    bus.iraw_we = 1'b0; bus.iraw_commit = 1'b1;
    tick();
    bus.iraw_commit = 1'b0;
    check("ready_b2", 32'(bus.obank_ready), 32'h04);
    check("cnt_b2", 32'(bus.oready_cnt), 32'h1);
    check("raw_free_b2", 32'(bus.oraw_free), 32'hFB);
    bus.ird_en = 1'b1; bus.ird_sel = 3'd2; bus.ird_addr = 10'd5; bus.ibypass = 1'b0;
    tick();
    bus.ird_en = 1'b0;
    check("xor_valid", 32'(bus.ordata_valid), 32'h1);
    check("xor_data", 32'(bus.ordata), 32'hA);
    check("xor_noerr", 32'(bus.oerr), 32'h0);
    tick();
    check("idle_valid", 32'(bus.ordata_valid), 32'h0);
    check("idle_hold", 32'(bus.ordata), 32'hA);

    // 2: OTP write to committed bank 2 is dropped and flags an error.
    bus.iotp_we = 1'b1; bus.iotp_sel = 3'd2; bus.iotp_addr = 10'd0; bus.iotp_wdata = 4'h3;
    tick();
    bus.iotp_we = 1'b0;
    check("wr_locked_err", 32'(bus.oerr), 32'h1);
    bus.ird_en = 1'b1; bus.ird_addr = 10'd0;
    tick();
    bus.ird_en = 1'b0;
    check("wr_dropped_data", 32'(bus.ordata), 32'hF);
    clear_err();
    check("err_clr", 32'(bus.oerr), 32'h0);

    // 3: bank 3 raw write + commit in one cycle; write must land before flag sets.
    bus.iraw_sel = 3'd3; bus.iraw_addr = 10'd7; bus.iraw_wdata = 4'h6;
    bus.iraw_we = 1'b1; bus.iraw_commit = 1'b1;
    tick();
    bus.iraw_we = 1'b0; bus.iraw_commit = 1'b0;
    check("raw_commit_noerr", 32'(bus.oerr), 32'h0);
    check("raw_free_b3", 32'(bus.oraw_free), 32'hF3);
    check("ready_still_b2", 32'(bus.obank_ready), 32'h04);
    bus.ird_en = 1'b1; bus.ird_sel = 3'd3; bus.ird_addr = 10'd7; bus.ibypass = 1'b0;
    tick();
    bus.ird_en = 1'b0;
    check("inelig_valid", 32'(bus.ordata_valid), 32'h1);
    check("inelig_data", 32'(bus.ordata), 32'h0);
    check("inelig_err", 32'(bus.oerr), 32'h1);
    clear_err();
    bus.ird_en = 1'b1; bus.ibypass = 1'b1;
    tick();
    bus.ird_en = 1'b0; bus.ibypass = 1'b0;
    check("bypass_data", 32'(bus.ordata), 32'h6);
    check("bypass_noerr", 32'(bus.oerr), 32'h0);
    // Re-committing an already-set raw flag.
    bus.iraw_commit = 1'b1;
    tick();
    bus.iraw_commit = 1'b0;
    check("recommit_err", 32'(bus.oerr), 32'h1);
    // Set beats clear when both happen in one cycle.
    bus.iraw_commit = 1'b1; bus.ierr_clr = 1'b1;
    tick();
    bus.iraw_commit = 1'b0; bus.ierr_clr = 1'b0;
    check("set_beats_clr", 32'(bus.oerr), 32'h1);
    clear_err();

    // 4: read and release bank 2 in the same cycle; read sees pre-release state.
    bus.ird_en = 1'b1; bus.irelease = 1'b1; bus.ird_sel = 3'd2; bus.ird_addr = 10'd5;
    tick();
    bus.ird_en = 1'b0; bus.irelease = 1'b0;
    check("rel_rd_valid", 32'(bus.ordata_valid), 32'h1);
    check("rel_rd_data", 32'(bus.ordata), 32'hA);
    check("rel_ready", 32'(bus.obank_ready), 32'h00);
    check("rel_otp_free", 32'(bus.ootp_free), 32'hFF);
    check("rel_raw_free", 32'(bus.oraw_free), 32'hF7);
    check("rel_noerr", 32'(bus.oerr), 32'h0);
    bus.irelease = 1'b1;
    tick();
    bus.irelease = 1'b0;
    check("rel_notready_err", 32'(bus.oerr), 32'h1);
    clear_err();

    // 5: bank 4 ready, then commit + release together: release wins with error.
    bus.iotp_sel = 3'd4; bus.iraw_sel = 3'd4;
    bus.iotp_commit = 1'b1; bus.iraw_commit = 1'b1;
    tick();
    bus.iotp_commit = 1'b0; bus.iraw_commit = 1'b0;
    check("dual_commit_ready", 32'(bus.obank_ready), 32'h10);
    check("dual_commit_cnt", 32'(bus.oready_cnt), 32'h1);
    bus.iotp_commit = 1'b1; bus.irelease = 1'b1; bus.ird_sel = 3'd4;
    tick();
    bus.iotp_commit = 1'b0; bus.irelease = 1'b0;
    check("relwin_ready", 32'(bus.obank_ready), 32'h00);
    check("relwin_otp_free", 32'(bus.ootp_free), 32'hFF);
    check("relwin_err", 32'(bus.oerr), 32'h1);
    clear_err();
    // Two ready banks for the population count.
    bus.iotp_sel = 3'd5; bus.iraw_sel = 3'd5;
    bus.iotp_commit = 1'b1; bus.iraw_commit = 1'b1;
    tick();
    bus.iotp_sel = 3'd6; bus.iraw_sel = 3'd6;
    tick();
    bus.iotp_commit = 1'b0; bus.iraw_commit = 1'b0;
    check("two_ready", 32'(bus.obank_ready), 32'h60);
    check("two_cnt", 32'(bus.oready_cnt), 32'h2);

    // Reset during a read result.
    bus.ird_en = 1'b1; bus.ird_sel = 3'd5; bus.ird_addr = 10'd1;
    tick();
    bus.ird_en = 1'b0;
    check("pre_rst_valid", 32'(bus.ordata_valid), 32'h1);
    irst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.ordata_valid), 32'h0);
    check("mid_rst_data", 32'(bus.ordata), 32'h0);
    check("mid_rst_otp_free", 32'(bus.ootp_free), 32'hFF);
    check("mid_rst_raw_free", 32'(bus.oraw_free), 32'hFF);
    check("mid_rst_ready", 32'(bus.obank_ready), 32'h00);
    check("mid_rst_cnt", 32'(bus.oready_cnt), 32'h0);
    tick();
    irst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
